// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback, one instruction at a time.
// Stalls in FETCH, MEM_RD and MEM_WR until mem_ready; all other states ignore it.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             Branch,
  output logic             ALUSrc,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Mem2Reg,
  output logic             RegWrite,
  output logic [1:0]       ALUOp,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    EXEC_R = 4'd3,
    EXEC_I = 4'd4,
    ADDR   = 4'd5,
    MEM_RD = 4'd6,
    MEM_WR = 4'd7,
    WB_ALU = 4'd8,
    WB_MEM = 4'd9,
    BRANCH = 4'd10,
    TRAP   = 4'd11
  } state_e;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire_raw, regwrite_raw, memwrite_raw, irwrite_raw, pcwrite_raw;

  // The branch decision (Branch & zero) is made in the datapath, not here.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    irwrite_raw  = 1'b0;
    pcwrite_raw  = 1'b0;
    Branch       = 1'b0;
    ALUSrc       = 1'b0;
    MemRead      = 1'b0;
    memwrite_raw = 1'b0;
    Mem2Reg      = 1'b0;
    regwrite_raw = 1'b0;
    ALUOp        = 2'b00;
    retire_raw   = 1'b0;
    illegal      = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        MemRead     = 1'b1;
        irwrite_raw = mem_ready;
        pcwrite_raw = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_R:               state_d = EXEC_R;
          OP_I:               state_d = EXEC_I;
          OP_LOAD, OP_STORE:  state_d = ADDR;
          OP_BRANCH:          state_d = BRANCH;
          default:            state_d = TRAP;
        endcase
      end
      EXEC_R: begin
        ALUOp   = 2'b10;
        state_d = WB_ALU;
      end
      EXEC_I: begin
        ALUOp   = 2'b11;
        ALUSrc  = 1'b1;
        state_d = WB_ALU;
      end
      ADDR: begin
        ALUSrc = 1'b1;
        if (opcode == OP_LOAD)       state_d = MEM_RD;
        else if (opcode == OP_STORE) state_d = MEM_WR;
        else                         state_d = TRAP;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        if (mem_ready) state_d = WB_MEM;
      end
      MEM_WR: begin
        memwrite_raw = 1'b1;
        retire_raw   = mem_ready;
        if (mem_ready) state_d = FETCH;
      end
      WB_ALU: begin
        regwrite_raw = 1'b1;
        retire_raw   = 1'b1;
        state_d      = FETCH;
      end
      WB_MEM: begin
        regwrite_raw = 1'b1;
        Mem2Reg      = 1'b1;
        retire_raw   = 1'b1;
        state_d      = FETCH;
      end
      BRANCH: begin
        Branch     = 1'b1;
        ALUOp      = 2'b01;
        retire_raw = 1'b1;
        state_d    = FETCH;
      end
      TRAP:    illegal = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  // Reset aborts the instruction in flight: suppress every architectural commit strobe.
  assign IRWrite  = irwrite_raw  & ~rst;
  assign PCWrite  = pcwrite_raw  & ~rst;
  assign MemWrite = memwrite_raw & ~rst;
  assign RegWrite = regwrite_raw & ~rst;
  assign retire   = retire_raw   & ~rst;

  assign cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, retire};
  assign instr_count = cnt_q;
  assign state       = state_q;

endmodule
